// File: rtl/instr_sequencer.sv
// instr_sequencer: FIFO-buffered instruction issue to the TPU control unit.
// Pops one host word per cycle onto a registered bus and holds the bus at an
// idle STORE word for the compute window that follows a START.
// Optional feature macro: SEQ_PERF_EN (issue / stall performance counters).
module instr_sequencer #(
    parameter int DEPTH          = 8,
    parameter int COMPUTE_CYCLES = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                host_instr,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       abort,
    output logic [15:0]                ctrl_instr,
    output logic                       issue_valid,
    output logic                       busy,
    output logic                       done,
`ifdef SEQ_PERF_EN
    output logic [15:0]                perf_issued,
    output logic [15:0]                perf_stall,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [1:0]  OP_START = 2'b00;
    localparam logic [1:0]  OP_STORE = 2'b11;
    localparam logic [15:0] STOP_WORD = 16'h4000;

    typedef enum logic {RUN, COMPUTE} state_t;

    state_t          state, state_next;
    logic [KW-1:0]   cnt, cnt_next;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      last_row, last_col;
    logic [15:0]     head, idle_word, ctrl_next;
    logic            push, pop, empty;
    logic            iv_next, busy_next, done_next;

    assign head       = mem[rd_ptr];
    assign empty      = (fifo_count == '0);
    assign host_ready = (fifo_count != CW'(DEPTH));
    assign push       = host_valid & host_ready;
    // Idle word re-selects the last STORE target so the array output mux stays put.
    assign idle_word  = {OP_STORE, 2'b00, last_row, last_col, 8'h00};

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_instr;
    end

    // FIFO pointers, occupancy and sticky STORE row/col.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_row   <= 2'b00;
            last_col   <= 2'b00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop && head[15:14] == OP_STORE) begin
                last_row <= head[11:10];
                last_col <= head[9:8];
            end
        end
    end

    // Sequencer state and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            ctrl_instr  <= 16'hC000;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            ctrl_instr  <= ctrl_next;
            issue_valid <= iv_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // Next-state: abort dominates; the compute window ends with done and may pop in the same edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        ctrl_next  = idle_word;
        iv_next    = 1'b0;
        busy_next  = busy;
        done_next  = 1'b0;
        if (abort) begin
            ctrl_next  = STOP_WORD;
            cnt_next   = '0;
            busy_next  = 1'b0;
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    pop = !empty;
                end
                COMPUTE: begin
                    if (cnt == '0) begin
                        state_next = RUN;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        pop        = !empty;
                    end else begin
                        cnt_next = cnt - KW'(1);
                    end
                end
                default: state_next = RUN;
            endcase
            if (pop) begin
                ctrl_next = head;
                iv_next   = 1'b1;
                if (head[15:14] == OP_START) begin
                    cnt_next   = KW'(COMPUTE_CYCLES);
                    state_next = COMPUTE;
                    busy_next  = 1'b1;
                end
            end
        end
    end

`ifdef SEQ_PERF_EN
    // Saturating counters: issued words and cycles with queued work held off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_valid && perf_issued != 16'hFFFF)
                perf_issued <= perf_issued + 16'd1;
            if (!empty && (busy || abort) && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven vectors plus hand-written compute/abort/reset
// sequences. Expected outputs are queued when a vector is driven and compared
// one cycle later after the clock edge.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] host_instr;
    logic        host_valid;
    logic        host_ready;
    logic        abort;
    logic [15:0] ctrl_instr;
    logic        issue_valid;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_count;
`ifdef SEQ_PERF_EN
    logic [15:0] perf_issued, perf_stall;
`endif

    instr_sequencer #(.DEPTH(8), .COMPUTE_CYCLES(11)) dut (
        .clk(clk), .rst_n(rst_n), .host_instr(host_instr), .host_valid(host_valid),
        .host_ready(host_ready), .abort(abort), .ctrl_instr(ctrl_instr),
        .issue_valid(issue_valid), .busy(busy), .done(done),
`ifdef SEQ_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        hv;
        logic [15:0] hi;
        logic        ab;
        logic [15:0] ci;
        logic        iv;
        logic        bz;
        logic        dn;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic [15:0] ci;
        logic        iv, bz, dn, rdy;
        logic [3:0]  cnt;
    } exp_t;

    exp_t  sb[$];
    vec_t  tbl[15];
    int    nvec = 0;
    int    nerr = 0;
    string tag  = "reset";

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic r, input logic hv, input logic [15:0] hi, input logic ab,
                        input logic [15:0] ci, input logic iv, input logic bz, input logic dn,
                        input logic [3:0] cnt);
        exp_t e, g;
        rst_n = r; host_valid = hv; host_instr = hi; abort = ab;
        e.ci = ci; e.iv = iv; e.bz = bz; e.dn = dn; e.cnt = cnt; e.rdy = (cnt != 4'd8);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        nvec++;
        if (ctrl_instr !== g.ci || issue_valid !== g.iv || busy !== g.bz || done !== g.dn ||
            fifo_count !== g.cnt || host_ready !== g.rdy) begin
            nerr++;
            $display("FAIL %s vec%0d: got ci=%h iv=%b busy=%b done=%b cnt=%0d rdy=%b, want ci=%h iv=%b busy=%b done=%b cnt=%0d rdy=%b",
                     tag, nvec, ctrl_instr, issue_valid, busy, done, fifo_count, host_ready,
                     g.ci, g.iv, g.bz, g.dn, g.cnt, g.rdy);
        end
    endtask

    task automatic apply(input vec_t v);
        step(v.rst_n, v.hv, v.hi, v.ab, v.ci, v.iv, v.bz, v.dn, v.cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; host_valid = 1'b0; host_instr = 16'h0; abort = 1'b0;

        //            rst hv  hi        ab  ci        iv bz dn cnt
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 16'h8512, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h8512, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b1, 16'h4000, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[6]  = '{1'b1, 1'b1, 16'h8123, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 1'b1, 16'hCB00, 1'b0, 16'h8123, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hCB00, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hCB00, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 1'b1, 16'hC400, 1'b0, 16'hCB00, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hC400, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hC400, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hC400, 1'b0, 1'b0, 1'b0, 4'd0};

        @(posedge clk); #1;
        tag = "table";
        for (int i = 0; i < 15; i++) apply(tbl[i]);

        // START then LOAD: 11 idle words, done coincides with the LOAD issue.
        tag = "start_window";
        step(1, 1, 16'h0000, 0, 16'hC400, 0, 0, 0, 4'd1);
        step(1, 1, 16'h8A00, 0, 16'h0000, 1, 1, 0, 4'd1);
        repeat (11) step(1, 0, 16'h0, 0, 16'hC400, 0, 1, 0, 4'd1);
        step(1, 0, 16'h0, 0, 16'h8A00, 1, 0, 1, 4'd0);
        step(1, 0, 16'h0, 0, 16'hC400, 0, 0, 0, 4'd0);

        // STORE CB00 then START: idle word during compute follows the STORE.
        tag = "sticky_store";
        step(1, 1, 16'hCB00, 0, 16'hC400, 0, 0, 0, 4'd1);
        step(1, 1, 16'h0000, 0, 16'hCB00, 1, 0, 0, 4'd1);
        step(1, 0, 16'h0,    0, 16'h0000, 1, 1, 0, 4'd0);
        repeat (11) step(1, 0, 16'h0, 0, 16'hCB00, 0, 1, 0, 4'd0);
        step(1, 0, 16'h0, 0, 16'hCB00, 0, 0, 1, 4'd0);
        step(1, 0, 16'h0, 0, 16'hCB00, 0, 0, 0, 4'd0);

        // Fill to DEPTH during compute, one refused push, then drain in order.
        tag = "fill_drain";
        step(1, 1, 16'h0000, 0, 16'hCB00, 0, 0, 0, 4'd1);
        step(1, 1, 16'h8001, 0, 16'h0000, 1, 1, 0, 4'd1);
        for (int i = 2; i <= 8; i++)
            step(1, 1, 16'h8000 | 16'(i), 0, 16'hCB00, 0, 1, 0, 4'(i));
        step(1, 1, 16'h80FF, 0, 16'hCB00, 0, 1, 0, 4'd8);
        repeat (3) step(1, 0, 16'h0, 0, 16'hCB00, 0, 1, 0, 4'd8);
        for (int i = 1; i <= 8; i++)
            step(1, 0, 16'h0, 0, 16'h8000 | 16'(i), 1, 0, logic'(i == 1), 4'(8 - i));
        step(1, 0, 16'h0, 0, 16'hCB00, 0, 0, 0, 4'd0);

        // Abort on the 5th compute cycle: STOP word, no done, queued LOAD kept.
        tag = "abort";
        step(1, 1, 16'h0000, 0, 16'hCB00, 0, 0, 0, 4'd1);
        step(1, 1, 16'h8055, 0, 16'h0000, 1, 1, 0, 4'd1);
        repeat (4) step(1, 0, 16'h0, 0, 16'hCB00, 0, 1, 0, 4'd1);
        step(1, 0, 16'h0, 1, 16'h4000, 0, 0, 0, 4'd1);
        step(1, 0, 16'h0, 0, 16'h8055, 1, 0, 0, 4'd0);
        repeat (12) step(1, 0, 16'h0, 0, 16'hCB00, 0, 0, 0, 4'd0);

        // Reset mid-compute with three words queued.
        tag = "reset_mid";
        step(1, 1, 16'h0000, 0, 16'hCB00, 0, 0, 0, 4'd1);
        step(1, 1, 16'h8001, 0, 16'h0000, 1, 1, 0, 4'd1);
        step(1, 1, 16'h8002, 0, 16'hCB00, 0, 1, 0, 4'd2);
        step(1, 1, 16'h8003, 0, 16'hCB00, 0, 1, 0, 4'd3);
        step(0, 0, 16'h0,    0, 16'hC000, 0, 0, 0, 4'd0);
        step(1, 0, 16'h0,    0, 16'hC000, 0, 0, 0, 4'd0);
        step(1, 1, 16'h8512, 0, 16'hC000, 0, 0, 0, 4'd1);
        step(1, 0, 16'h0,    0, 16'h8512, 1, 0, 0, 4'd0);
        step(1, 0, 16'h0,    0, 16'hC000, 0, 0, 0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
